rs_exp_mod255_accum: RTL and testbench

//  Consumes the 10-bit products of the 5x5 unsigned_multiplier in the RS(255,n) datapath.

---
 rtl/rs_exp_mod255_accum.sv | 128 ++++++++++++
 tb/tb_rs_exp_mod255_accum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rs_exp_mod255_accum.sv
// rs_exp_mod255_accum: folds 10-bit multiplier products mod 255, accumulates the
// residues over a framed sequence of terms, and emits one log-domain exponent
// plus a saturating term count per frame, behind a valid/ready handshake.
module rs_exp_mod255_accum #(
  parameter int PROD_W = 10,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_count
);

  // Modulus 2^EXP_W - 1, held one bit wider so sums can be compared directly.
  localparam logic [EXP_W:0] MOD     = {1'b0, {EXP_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              s1_valid_q, s1_valid_d;
  logic [EXP_W-1:0]  s1_r_q, s1_r_d;
  logic              s1_sof_q, s1_sof_d;
  logic              s1_eof_q, s1_eof_d;
  logic [EXP_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic              adv;
  logic [EXP_W:0]    fold_sum;
  logic [EXP_W-1:0]  fold_r;
  logic [EXP_W-1:0]  acc_base;
  logic [EXP_W:0]    acc_sum;
  logic [EXP_W-1:0]  acc_new;
  logic [CNT_W-1:0]  cnt_new;

  // Since 2^8 == 1 mod 255, the high product bits fold onto the low byte; one
  // conditional subtract suffices because the folded sum is below 2*255.
  always_comb begin
    fold_sum = {1'b0, in_prod[EXP_W-1:0]} + (EXP_W+1)'(in_prod[PROD_W-1:EXP_W]);
    if (fold_sum >= MOD) fold_r = EXP_W'(fold_sum - MOD);
    else                 fold_r = EXP_W'(fold_sum);
  end

  // Accumulate the stage-1 residue; a start-of-frame beat restarts from zero.
  always_comb begin
    acc_base = s1_sof_q ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {1'b0, s1_r_q};
    if (acc_sum >= MOD) acc_new = EXP_W'(acc_sum - MOD);
    else                acc_new = EXP_W'(acc_sum);
    if (s1_sof_q)              cnt_new = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_new = cnt_q;
    else                       cnt_new = cnt_q + CNT_W'(1);
  end

  // Whole pipeline moves together whenever the output slot is free or draining.
  always_comb begin
    adv         = !out_valid_q || out_ready;
    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    s1_sof_d    = s1_sof_q;
    s1_eof_d    = s1_eof_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_exp_d   = out_exp_q;
    out_count_d = out_count_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      if (in_valid) begin
        s1_r_d   = fold_r;
        s1_sof_d = in_sof;
        s1_eof_d = in_eof;
      end
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (s1_eof_q) begin
          out_valid_d = 1'b1;
          out_exp_d   = acc_new;
          out_count_d = cnt_new;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_new;
          cnt_d = cnt_new;
        end
      end
    end
  end

  // State registers; reset drops any in-flight frame and pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_exp_q   <= '0;
      out_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      s1_sof_q    <= s1_sof_d;
      s1_eof_q    <= s1_eof_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_exp_q   <= out_exp_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_exp   = out_exp_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_rs_exp_mod255_accum.sv
// Directed bench for rs_exp_mod255_accum with hand-computed expected values.
module tb_rs_exp_mod255_accum;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_prod;
  logic       in_sof;
  logic       in_eof;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_exp;
  logic [5:0] out_count;

  int testCount = 0;
  int failCount = 0;

  rs_exp_mod255_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_count (out_count)
  );

  // 10 ns free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance, then withdraw it.
  task automatic applyStimulus(input int prod, input bit sof, input bit eof);
    int waited = 0;
    in_valid = 1'b1;
    in_prod  = prod[9:0];
    in_sof   = sof;
    in_eof   = eof;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  // Wait (bounded) for a result, check it, and consume it with out_ready=1.
  task automatic expectResult(input string tag, input int expExp, input int expCnt);
    int waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 1);
    checkOutput({tag, "_exp"}, 32'(out_exp), expExp);
    checkOutput({tag, "_count"}, 32'(out_count), expCnt);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_sof    = 1'b0;
    in_eof    = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_out_exp", 32'(out_exp), 0);
    checkOutput("reset_out_count", 32'(out_count), 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 1);
    tick();

    // Test 1: single-term frame 961 -> 196, result exactly two edges after accept
    in_valid = 1'b1; in_prod = 10'd961; in_sof = 1'b1; in_eof = 1'b1;
    tick();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    checkOutput("t1_not_early", 32'(out_valid), 0);
    tick();
    checkOutput("t1_latency_valid", 32'(out_valid), 1);
    checkOutput("t1_exp", 32'(out_exp), 196);
    checkOutput("t1_count", 32'(out_count), 1);
    tick();
    checkOutput("t1_drop", 32'(out_valid), 0);

    // Test 2: 255,510,254 -> 0+0+254
    applyStimulus(255, 1, 0);
    applyStimulus(510, 0, 0);
    applyStimulus(254, 0, 1);
    expectResult("t2", 254, 3);

    // Test 3: 200+100 wraps to 45; then single 0; then un-sof'd single beat
    applyStimulus(200, 1, 0);
    applyStimulus(100, 0, 1);
    expectResult("t3a", 45, 1 + 1);
    applyStimulus(0, 1, 1);
    expectResult("t3b", 0, 1);
    applyStimulus(3, 0, 1);
    expectResult("t3c_nosof", 3, 1);

    // Test 4: backpressure holds result 5 and stalls 9 until out_ready rises
    out_ready = 1'b0;
    applyStimulus(5, 1, 1);
    applyStimulus(9, 1, 1);
    checkOutput("t4_in_ready_low", 32'(in_ready), 0);
    checkOutput("t4_first_valid", 32'(out_valid), 1);
    checkOutput("t4_first_exp", 32'(out_exp), 5);
    tick(); tick(); tick();
    checkOutput("t4_hold_valid", 32'(out_valid), 1);
    checkOutput("t4_hold_exp", 32'(out_exp), 5);
    out_ready = 1'b1;
    #1;
    checkOutput("t4_release_in_ready", 32'(in_ready), 1);
    tick();
    checkOutput("t4_second_valid", 32'(out_valid), 1);
    checkOutput("t4_second_exp", 32'(out_exp), 9);
    tick();
    checkOutput("t4_drain", 32'(out_valid), 0);

    // Sof mid-frame discards the partial sum
    applyStimulus(50, 1, 0);
    applyStimulus(30, 1, 1);
    expectResult("midsof", 30, 1);

    // Test 5: reset mid-frame, then fresh frames
    applyStimulus(7, 1, 0);
    applyStimulus(8, 0, 0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_valid", 32'(out_valid), 0);
    checkOutput("t5_rst_exp", 32'(out_exp), 0);
    checkOutput("t5_rst_count", 32'(out_count), 0);
    tick();
    reset = 1'b0;
    #1;
    applyStimulus(7, 0, 1);
    expectResult("t5_acc_cleared", 7, 1);
    applyStimulus(7, 1, 1);
    expectResult("t5_new", 7, 1);

    // Reset drops a pending, unaccepted result
    out_ready = 1'b0;
    applyStimulus(11, 1, 1);
    tick();
    checkOutput("pend_valid", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    checkOutput("pend_dropped", 32'(out_valid), 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;

    // Test 6: 70 ones -> exp 70, count saturates at 63
    for (int i = 0; i < 70; i++) applyStimulus(1, i == 0, i == 69);
    expectResult("t6", 70, 63);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
